// File: rtl/usb3_tx_pkg.sv
// Shared definitions for the USB3 TX symbol path: symbol width, comma
// symbols, default bit order, serializer state encoding and bit-order helpers.
package usb3_tx_pkg;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] K28_5_RD_NEG = 10'b0011111010;
    localparam logic [SYM_W-1:0] K28_5_RD_POS = 10'b1100000101;

    // Bit 'a' of an 8b/10b symbol sits at din[9], and it goes out first.
    localparam bit MSB_FIRST_DFLT = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    function automatic logic lead_bit(input logic [SYM_W-1:0] sym, input logic msb_first);
        return msb_first ? sym[SYM_W-1] : sym[0];
    endfunction

    function automatic logic [SYM_W-1:0] shift_sym(input logic [SYM_W-1:0] sym, input logic msb_first);
        return msb_first ? {sym[SYM_W-2:0], 1'b0} : {1'b0, sym[SYM_W-1:1]};
    endfunction

endpackage

// File: rtl/usb3_sym_fifo.sv
// Synchronous show-ahead symbol FIFO. A write while full is still accepted
// when a read happens on the same edge; otherwise the write is dropped.
module usb3_sym_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic          wr_drop,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          wr_ok_s;
    logic          rd_ok_s;

    assign full    = (count_r == (AW+1)'(DEPTH));
    assign empty   = (count_r == {(AW+1){1'b0}});
    assign rd_ok_s = rd_en && !empty;
    assign wr_ok_s = wr_en && (!full || rd_ok_s);
    assign wr_drop = wr_en && !wr_ok_s;
    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/tx_serializer_10b.sv
// 10-bit symbol serializer: buffers encoder symbols in a small FIFO and shifts
// them out one bit per clock, back-to-back while data is available.
module tx_serializer_10b #(
    parameter int SYM_W      = usb3_tx_pkg::SYM_W,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = usb3_tx_pkg::MSB_FIRST_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] din,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             sym_start,
    output logic             underrun,
    output logic             overflow
);

    import usb3_tx_pkg::*;

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  LAST_BIT = 4'(SYM_W - 1);

    ser_state_e       state_r, state_n;
    logic [SYM_W-1:0] shift_r, shift_n;
    logic [3:0]       bit_cnt_r, bit_cnt_n;
    logic             ser_out_r, ser_out_n;
    logic             ser_valid_r, ser_valid_n;
    logic             sym_start_r, sym_start_n;
    logic             underrun_r, underrun_n;
    logic             overflow_r;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             fifo_drop_s;
    logic [SYM_W-1:0] fifo_rd_data_s;
    logic [AW:0]      fifo_count_s;

    usb3_sym_fifo #(
        .W     (SYM_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_valid),
        .wr_data (din),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .wr_drop (fifo_drop_s),
        .count   (fifo_count_s)
    );

    assign in_ready  = (fifo_count_s != (AW+1)'(FIFO_DEPTH));
    assign ser_out   = ser_out_r;
    assign ser_valid = ser_valid_r;
    assign sym_start = sym_start_r;
    assign underrun  = underrun_r;
    assign overflow  = overflow_r;

    // Next-state logic: ser_out_n is always the bit shown in the coming cycle.
    always_comb begin
        state_n     = state_r;
        shift_n     = shift_r;
        bit_cnt_n   = bit_cnt_r;
        ser_out_n   = 1'b0;
        ser_valid_n = 1'b0;
        sym_start_n = 1'b0;
        underrun_n  = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    shift_n     = fifo_rd_data_s;
                    bit_cnt_n   = 4'd0;
                    ser_out_n   = lead_bit(fifo_rd_data_s, MSB_FIRST);
                    ser_valid_n = 1'b1;
                    sym_start_n = 1'b1;
                    state_n     = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (bit_cnt_r != LAST_BIT) begin
                    shift_n     = shift_sym(shift_r, MSB_FIRST);
                    bit_cnt_n   = bit_cnt_r + 4'd1;
                    ser_out_n   = lead_bit(shift_n, MSB_FIRST);
                    ser_valid_n = 1'b1;
                end else if (!fifo_empty_s) begin
                    // Chain straight into the next symbol with no gap bit.
                    pop_s       = 1'b1;
                    shift_n     = fifo_rd_data_s;
                    bit_cnt_n   = 4'd0;
                    ser_out_n   = lead_bit(fifo_rd_data_s, MSB_FIRST);
                    ser_valid_n = 1'b1;
                    sym_start_n = 1'b1;
                end else begin
                    shift_n    = {SYM_W{1'b0}};
                    bit_cnt_n  = 4'd0;
                    underrun_n = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: begin
                shift_n   = {SYM_W{1'b0}};
                bit_cnt_n = 4'd0;
                state_n   = IDLE;
            end
        endcase
    end

    // State, shifter and registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            shift_r     <= {SYM_W{1'b0}};
            bit_cnt_r   <= 4'd0;
            ser_out_r   <= 1'b0;
            ser_valid_r <= 1'b0;
            sym_start_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            shift_r     <= shift_n;
            bit_cnt_r   <= bit_cnt_n;
            ser_out_r   <= ser_out_n;
            ser_valid_r <= ser_valid_n;
            sym_start_r <= sym_start_n;
            underrun_r  <= underrun_n;
        end
    end

    // Sticky drop flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | fifo_drop_s;
        end
    end

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Directed self-checking bench for tx_serializer_10b (MSB-first and LSB-first instances).
module tb_tx_serializer_10b;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [9:0] din;
    logic       in_ready, ser_out, ser_valid, sym_start, underrun, overflow;
    logic       in_valid2;
    logic [9:0] din2;
    logic       in_ready2, ser_out2, ser_valid2, sym_start2, underrun2, overflow2;

    int n_assert = 0;
    int n_fail   = 0;

    tx_serializer_10b #(.SYM_W(10), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din),
        .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .sym_start(sym_start), .underrun(underrun), .overflow(overflow)
    );

    tx_serializer_10b #(.SYM_W(10), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .din(din2),
        .in_ready(in_ready2), .ser_out(ser_out2), .ser_valid(ser_valid2),
        .sym_start(sym_start2), .underrun(underrun2), .overflow(overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sym(input logic [9:0] d);
        in_valid = 1'b1;
        din      = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a symbol start, then collect its 10 bits MSB-first.
    task automatic recv_sym(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        int k;
        k = 0;
        while (sym_start !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_start_seen"}, 32'(k < 40), 32'd1);
        got = 10'd0;
        for (int b = 0; b < 10; b++) begin
            got[9-b] = ser_out;
            chk({tag, "_valid"}, 32'(ser_valid), 32'd1);
            tick();
        end
        chk({tag, "_data"}, 32'(got), 32'(exp));
    endtask

    initial begin
        logic [9:0]  single;
        logic [19:0] pair;
        logic [9:0]  ov_syms [6];
        int          vcnt;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        din       = 10'd0;
        in_valid2 = 1'b0;
        din2      = 10'd0;
        #12;
        chk("rst_ser_out",   32'(ser_out),   32'd0);
        chk("rst_ser_valid", 32'(ser_valid), 32'd0);
        chk("rst_sym_start", 32'(sym_start), 32'd0);
        chk("rst_underrun",  32'(underrun),  32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single K28.5 RD-: expected bits 0,0,1,1,1,1,1,0,1,0
        single = 10'b0011111010;
        write_sym(single);
        chk("single_no_bypass", 32'(ser_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("single_bit",   32'(ser_out),   32'(single[9-i]));
            chk("single_valid", 32'(ser_valid), 32'd1);
            chk("single_start", 32'(sym_start), 32'(i == 0));
        end
        tick();
        chk("single_underrun", 32'(underrun),  32'd1);
        chk("single_idle",     32'(ser_valid), 32'd0);
        tick();
        chk("single_underrun_pulse", 32'(underrun), 32'd0);

        // Back-to-back D0.0 RD- then K28.5 RD+, written 10 cycles apart
        pair = {10'b1001110100, 10'b1100000101};
        write_sym(10'b1001110100);
        for (int i = 0; i < 20; i++) begin
            if (i == 9) begin
                in_valid = 1'b1;
                din      = 10'b1100000101;
            end
            tick();
            in_valid = 1'b0;
            chk("b2b_bit",      32'(ser_out),   32'(pair[19-i]));
            chk("b2b_valid",    32'(ser_valid), 32'd1);
            chk("b2b_start",    32'(sym_start), 32'(i == 0 || i == 10));
            chk("b2b_underrun", 32'(underrun),  32'd0);
        end
        tick();
        chk("b2b_underrun_end", 32'(underrun),  32'd1);
        chk("b2b_idle",         32'(ser_valid), 32'd0);

        // Full FIFO with a write on the pop edge (bit_cnt==9)
        write_sym(10'b0011111010);
        tick();
        write_sym(10'b1001110100);
        write_sym(10'b1100000101);
        write_sym(10'b0011111010);
        write_sym(10'b0110001011);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        write_sym(10'b1010101010);
        chk("full_pop_overflow", 32'(overflow), 32'd0);
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        recv_sym("full_s1", 10'b1001110100);
        recv_sym("full_s2", 10'b1100000101);
        recv_sym("full_s3", 10'b0011111010);
        recv_sym("full_s4", 10'b0110001011);
        recv_sym("full_s5", 10'b1010101010);
        chk("full_underrun", 32'(underrun), 32'd1);
        chk("full_overflow_end", 32'(overflow), 32'd0);

        // Asynchronous reset at bit 4 of a symbol with another one queued
        write_sym(10'b1010101010);
        write_sym(10'b0110001011);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_pre_bit4",  32'(ser_out),   32'd1);
        chk("mid_pre_valid", 32'(ser_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ser_out",   32'(ser_out),   32'd0);
        chk("mid_rst_ser_valid", 32'(ser_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ser_valid === 1'b1) vcnt++;
        end
        chk("mid_rst_silent", 32'(vcnt), 32'd0);

        // Overflow: shifter busy, six writes on consecutive cycles
        ov_syms = '{10'b1001110100, 10'b1100000101, 10'b0011111010,
                    10'b0110001011, 10'b1010101010, 10'b0101010101};
        write_sym(10'b1111100000);
        tick();
        for (int i = 0; i < 6; i++) begin
            write_sym(ov_syms[i]);
            if (i == 3) begin
                chk("ov_in_ready_4th", 32'(in_ready), 32'd0);
                chk("ov_overflow_4th", 32'(overflow), 32'd0);
            end
            if (i == 4) chk("ov_overflow_5th", 32'(overflow), 32'd1);
        end
        recv_sym("ov_s1", ov_syms[0]);
        recv_sym("ov_s2", ov_syms[1]);
        recv_sym("ov_s3", ov_syms[2]);
        recv_sym("ov_s4", ov_syms[3]);
        chk("ov_underrun", 32'(underrun),  32'd1);
        chk("ov_idle",     32'(ser_valid), 32'd0);
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ser_valid === 1'b1) vcnt++;
        end
        chk("ov_dropped_silent", 32'(vcnt), 32'd0);
        chk("ov_sticky",         32'(overflow), 32'd1);

        // LSB-first instance: 10'b0000000001 gives 1 then nine 0s
        in_valid2 = 1'b1;
        din2      = 10'b0000000001;
        tick();
        in_valid2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("lsb_bit",   32'(ser_out2),   32'(i == 0));
            chk("lsb_valid", 32'(ser_valid2), 32'd1);
            chk("lsb_start", 32'(sym_start2), 32'(i == 0));
        end
        tick();
        chk("lsb_underrun", 32'(underrun2), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_serializer_10b.md
Name: tx_serializer_10b

Overview:
Parallel-to-serial stage directly downstream of the 8b/10b encoder in the USB3 TX PHY path. Captures each 10-bit encoded symbol with its valid strobe into a small synchronous FIFO, then shifts it out one bit per clock, bit 'a' first. Symbols stream back-to-back with no gap bits while the FIFO holds data. The block flags FIFO overflow and stream underrun.

Parameters:
- SYM_W, 10: symbol width; fixed by 8b/10b, must be 10.
- FIFO_DEPTH, 4: symbol FIFO entries; power of 2, minimum 2.
- MSB_FIRST, 1: 1 transmits din[9] (bit 'a') first; 0 transmits din[0] first.

Ports:
- clk  in  1  single clock; bit-rate clock, one serial bit per cycle
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  symbol strobe from the encoder (its dout_valid)
- din  in  10  encoded symbol from the encoder (its dout)
- in_ready  out  1  high when the FIFO is not full; advisory only, the encoder has no backpressure
- ser_out  out  1  serial data bit
- ser_valid  out  1  ser_out carries symbol data this cycle
- sym_start  out  1  high during the cycle ser_out carries the first bit of a symbol
- underrun  out  1  one-cycle pulse when streaming stops because the FIFO is empty
- overflow  out  1  sticky; set when a symbol is dropped, cleared only by reset

Behaviour:
- Reset: the asynchronous assertion of rst_n clears all state immediately.
  - FIFO pointers and count go to 0; shift register and bit counter go to 0; state goes to IDLE.
  - Outputs after reset: ser_out=0, ser_valid=0, sym_start=0, underrun=0, overflow=0, in_ready=1.
  - A reset mid-symbol discards the partial symbol and all FIFO contents. No flush occurs.
- FIFO write:
  - On a clk edge with in_valid=1 and FIFO not full, din is written.
  - If the FIFO is full but a read occurs on the same edge, the write is still accepted.
  - If the FIFO is full and no read occurs, the symbol is dropped and overflow is set to 1.
- in_ready = (count != FIFO_DEPTH), driven combinationally from the registered count.
- State machine (two states, IDLE and SHIFT):
  - IDLE: ser_valid=0, ser_out=0. At an edge where the FIFO is non-empty, pop the head symbol, load the shift register, set bit_cnt=0, and go to SHIFT.
  - SHIFT: ser_out is the current bit, with ser_valid=1. Each edge advances the shift and increments bit_cnt.
  - At the edge where bit_cnt==9:
    - FIFO non-empty: pop and load the next symbol, set bit_cnt=0, and stay in SHIFT. There is no gap cycle.
    - FIFO empty: go to IDLE, ser_valid<=0, and pulse underrun for one cycle.
- Bit order: with MSB_FIRST=1, bits go out din[9], din[8], … din[0]. With MSB_FIRST=0 the order is reversed.
- sym_start=1 exactly in the cycle holding bit index 0 of each symbol.
- Latency: a symbol written at edge E into an empty FIFO while IDLE is popped at edge E+1. Its first bit is on ser_out from edge E+1 to E+2, and its last bit from E+10 to E+11.
- Simultaneous write and pop on the same edge: the count is unchanged. A write into an empty FIFO is not readable on that same edge (no bypass).
- The FIFO count is (log2(FIFO_DEPTH)+1) bits wide. Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Throughput: sustained input must average no more than 1 symbol per 10 cycles. Exceeding this eventually sets overflow.
- ser_out, ser_valid, sym_start and underrun are all registered.

Decomposition:
- Shared package usb3_tx_pkg holds:
  - SYM_W=10
  - K28_5_RD_NEG=10'b0011111010 and K28_5_RD_POS=10'b1100000101
  - the bit-order constant
  - state encoding IDLE/SHIFT
- One natural sub-module, usb3_sym_fifo: a synchronous FIFO of width SYM_W and depth FIFO_DEPTH, providing wr_en, rd_en, full, empty and count.

Test Plan:
- Single symbol: write 10'b0011111010 at edge E with the block idle. Required: ser_out sequence 0,0,1,1,1,1,1,0,1,0 from E+1; sym_start high only at E+1; ser_valid high for exactly 10 cycles; underrun pulses at E+11.
- Back-to-back: write D0.0 RD- (10'b1001110100) then K28.5 RD+ (10'b1100000101) 10 cycles apart. Required: 20 contiguous valid bits with no gap; sym_start at bit 0 and bit 10; one underrun after bit 19.
- Overflow: with FIFO_DEPTH=4 and the shifter busy, write 6 symbols on consecutive cycles. Required: in_ready=0 after the 4th write; overflow=1 after the 5th; exactly 5 symbols emitted (the one in flight plus 4 buffered); the 6th is dropped.
- Full with simultaneous pop: FIFO full, write on the edge where bit_cnt==9. Required: write accepted, overflow stays 0, count stays 4.
- Reset mid-symbol: assert rst_n=0 asynchronously at bit 4 of a symbol. Required: ser_out=0, ser_valid=0 and in_ready=1 immediately; after release, nothing is emitted until a new write.
- MSB_FIRST=0: write 10'b0000000001. Required: ser_out is 1 in the first bit and 0 in the remaining 9.
